// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter: FSM states, read-owner tags
// and default bus widths.
package mem_arb_pkg;

  localparam int DEF_AW = 8;
  localparam int DEF_DW = 16;
  localparam int CNT_W  = 4;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the CPU, debug and memory-side signals around the arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_port_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 16
);

  logic          cpu_req;
  logic          cpu_wr;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;

  logic          dbg_req;
  logic          dbg_wr;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_lock;
  logic          dbg_gnt;
  logic          dbg_rvalid;
  logic [DW-1:0] dbg_rdata;

  logic          mem_rd;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          locked;

  modport slave (
    input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
    input  dbg_req, dbg_wr, dbg_addr, dbg_wdata, dbg_lock,
    input  mem_rdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata, cpu_stall,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output mem_rd, mem_wr, mem_addr, mem_wdata,
    output locked
  );

  modport master (
    output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
    output dbg_req, dbg_wr, dbg_addr, dbg_wdata, dbg_lock,
    output mem_rdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata, cpu_stall,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  mem_rd, mem_wr, mem_addr, mem_wdata,
    input  locked
  );

endinterface

// File: rtl/mem_port_arbiter_router.sv
// Read-return router: remembers who owns the read issued this cycle and
// steers the memory's next-cycle data to that owner; the other side holds.
module read_return_router
  import mem_arb_pkg::*;
#(
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_issue,
  input  owner_e        i_owner,
  input  logic [DW-1:0] i_mem_rdata,
  output logic          o_cpu_rvalid,
  output logic [DW-1:0] o_cpu_rdata,
  output logic          o_dbg_rvalid,
  output logic [DW-1:0] o_dbg_rdata
);

  logic          r_pend;
  owner_e        r_owner;
  logic [DW-1:0] r_cpu_hold;
  logic [DW-1:0] r_dbg_hold;
  logic          w_cpu_rv;
  logic          w_dbg_rv;

  // Tag pipeline and per-owner hold registers for the last returned word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend     <= 1'b0;
      r_owner    <= OWN_CPU;
      r_cpu_hold <= {DW{1'b0}};
      r_dbg_hold <= {DW{1'b0}};
    end else begin
      r_pend  <= i_issue;
      r_owner <= i_owner;
      if (w_cpu_rv) begin
        r_cpu_hold <= i_mem_rdata;
      end else begin
        r_cpu_hold <= r_cpu_hold;
      end
      if (w_dbg_rv) begin
        r_dbg_hold <= i_mem_rdata;
      end else begin
        r_dbg_hold <= r_dbg_hold;
      end
    end
  end

  // A tag left over from before reset must never surface as a valid.
  always_comb begin
    w_cpu_rv = 1'b0;
    w_dbg_rv = 1'b0;
    if (!rst && r_pend) begin
      w_cpu_rv = (r_owner == OWN_CPU);
      w_dbg_rv = (r_owner == OWN_DBG);
    end else begin
      w_cpu_rv = 1'b0;
      w_dbg_rv = 1'b0;
    end
  end

  assign o_cpu_rvalid = w_cpu_rv;
  assign o_dbg_rvalid = w_dbg_rv;
  assign o_cpu_rdata  = rst ? {DW{1'b0}} : (w_cpu_rv ? i_mem_rdata : r_cpu_hold);
  assign o_dbg_rdata  = rst ? {DW{1'b0}} : (w_dbg_rv ? i_mem_rdata : r_dbg_hold);

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single memory port: CPU has fixed priority,
// debug gets a forced slot after STARVE_LIMIT contested losses, and can lock the bus.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW           = DEF_AW,
  parameter int DW           = DEF_DW,
  parameter int STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  arb_state_e       r_state;
  arb_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_starve_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_cpu_gnt;
  logic             w_dbg_gnt;
  logic             w_mem_rd;
  logic             w_mem_wr;
  logic [AW-1:0]    w_mem_addr;
  logic [DW-1:0]    w_mem_wdata;
  logic             w_rd_issue;
  owner_e           w_rd_owner;

  // FSM state and starvation counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ARB;
      r_starve_cnt <= {CNT_W{1'b0}};
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_cnt_nxt;
    end
  end

  // Grant decision and next state; nothing is granted while reset is held.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_starve_cnt;
    w_cpu_gnt   = 1'b0;
    w_dbg_gnt   = 1'b0;
    if (rst) begin
      w_state_nxt = ARB;
      w_cnt_nxt   = {CNT_W{1'b0}};
    end else begin
      case (r_state)
        ARB: begin
          if (bus.cpu_req && bus.dbg_req) begin
            if (r_starve_cnt == LIMIT) begin
              w_dbg_gnt = 1'b1;
              w_cnt_nxt = {CNT_W{1'b0}};
            end else begin
              w_cpu_gnt = 1'b1;
              w_cnt_nxt = r_starve_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
          end else if (bus.cpu_req) begin
            w_cpu_gnt = 1'b1;
            w_cnt_nxt = {CNT_W{1'b0}};
          end else if (bus.dbg_req) begin
            w_dbg_gnt = 1'b1;
            w_cnt_nxt = {CNT_W{1'b0}};
          end else begin
            w_cnt_nxt = {CNT_W{1'b0}};
          end
          if (w_dbg_gnt && bus.dbg_lock) begin
            w_state_nxt = LOCK;
          end else begin
            w_state_nxt = ARB;
          end
        end
        LOCK: begin
          w_dbg_gnt = bus.dbg_req;
          w_cnt_nxt = {CNT_W{1'b0}};
          if (bus.dbg_lock) begin
            w_state_nxt = LOCK;
          end else begin
            w_state_nxt = ARB;
          end
        end
        default: begin
          w_state_nxt = ARB;
          w_cnt_nxt   = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // Command mux: the winner drives the memory port, otherwise it idles at zero.
  always_comb begin
    w_mem_rd    = 1'b0;
    w_mem_wr    = 1'b0;
    w_mem_addr  = {AW{1'b0}};
    w_mem_wdata = {DW{1'b0}};
    w_rd_owner  = OWN_CPU;
    if (w_cpu_gnt) begin
      w_mem_rd    = ~bus.cpu_wr;
      w_mem_wr    = bus.cpu_wr;
      w_mem_addr  = bus.cpu_addr;
      w_mem_wdata = bus.cpu_wdata;
      w_rd_owner  = OWN_CPU;
    end else if (w_dbg_gnt) begin
      w_mem_rd    = ~bus.dbg_wr;
      w_mem_wr    = bus.dbg_wr;
      w_mem_addr  = bus.dbg_addr;
      w_mem_wdata = bus.dbg_wdata;
      w_rd_owner  = OWN_DBG;
    end else begin
      w_rd_owner  = OWN_CPU;
    end
  end

  assign w_rd_issue = w_mem_rd;

  read_return_router #(
    .DW (DW)
  ) u_router (
    .clk          (clk),
    .rst          (rst),
    .i_issue      (w_rd_issue),
    .i_owner      (w_rd_owner),
    .i_mem_rdata  (bus.mem_rdata),
    .o_cpu_rvalid (bus.cpu_rvalid),
    .o_cpu_rdata  (bus.cpu_rdata),
    .o_dbg_rvalid (bus.dbg_rvalid),
    .o_dbg_rdata  (bus.dbg_rdata)
  );

  assign bus.cpu_gnt   = w_cpu_gnt;
  assign bus.dbg_gnt   = w_dbg_gnt;
  assign bus.mem_rd    = w_mem_rd;
  assign bus.mem_wr    = w_mem_wr;
  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_wdata = w_mem_wdata;
  assign bus.cpu_stall = bus.cpu_req && !w_cpu_gnt && !rst;
  assign bus.locked    = (r_state == LOCK) && !rst;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a 256x16 synchronous-read memory model.
module tb_mem_port_arbiter;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  logic [15:0] mem [0:255];

  mem_port_arbiter_if #(.AW(8), .DW(16)) bus ();

  mem_port_arbiter #(
    .AW           (8),
    .DW           (16),
    .STARVE_LIMIT (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Memory model; a few known words are (re)loaded while reset is held.
  always @(posedge clk) begin
    if (rst) begin
      mem[8'h10] <= 16'hBEEF;
      mem[8'h20] <= 16'h1234;
      mem[8'h21] <= 16'h5678;
    end else begin
      if (bus.mem_wr) mem[bus.mem_addr] <= bus.mem_wdata;
    end
    if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic c_req, input logic c_wr, input logic [7:0] c_addr,
                       input logic [15:0] c_wd, input logic d_req, input logic d_wr,
                       input logic [7:0] d_addr, input logic [15:0] d_wd, input logic d_lock);
    bus.cpu_req   = c_req;
    bus.cpu_wr    = c_wr;
    bus.cpu_addr  = c_addr;
    bus.cpu_wdata = c_wd;
    bus.dbg_req   = d_req;
    bus.dbg_wr    = d_wr;
    bus.dbg_addr  = d_addr;
    bus.dbg_wdata = d_wd;
    bus.dbg_lock  = d_lock;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_cpu_gnt"},    32'(bus.cpu_gnt),    32'd0);
    check_eq({tag, "_dbg_gnt"},    32'(bus.dbg_gnt),    32'd0);
    check_eq({tag, "_cpu_rvalid"}, 32'(bus.cpu_rvalid), 32'd0);
    check_eq({tag, "_dbg_rvalid"}, 32'(bus.dbg_rvalid), 32'd0);
    check_eq({tag, "_cpu_rdata"},  32'(bus.cpu_rdata),  32'd0);
    check_eq({tag, "_dbg_rdata"},  32'(bus.dbg_rdata),  32'd0);
    check_eq({tag, "_mem_rd"},     32'(bus.mem_rd),     32'd0);
    check_eq({tag, "_mem_wr"},     32'(bus.mem_wr),     32'd0);
    check_eq({tag, "_mem_addr"},   32'(bus.mem_addr),   32'd0);
    check_eq({tag, "_mem_wdata"},  32'(bus.mem_wdata),  32'd0);
    check_eq({tag, "_cpu_stall"},  32'(bus.cpu_stall),  32'd0);
    check_eq({tag, "_locked"},     32'(bus.locked),     32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clk      = 1'b0;
    rst      = 1'b1;
    bus.mem_rdata = 16'h0000;
    idle();

    // Reset state, with requests held high to expose ungated grants.
    drive(1'b1, 1'b0, 8'h10, 16'h0000, 1'b1, 1'b0, 8'h11, 16'h0000, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");

    // Idle after reset.
    next_cycle(); rst = 1'b0; idle();
    @(negedge clk);
    check_all_zero("idle");

    // CPU read of 0x10.
    next_cycle(); drive(1'b1, 1'b0, 8'h10, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0);
    @(negedge clk);
    check_eq("rd_cpu_gnt",   32'(bus.cpu_gnt),    32'd1);
    check_eq("rd_mem_rd",    32'(bus.mem_rd),     32'd1);
    check_eq("rd_mem_addr",  32'(bus.mem_addr),   32'h10);
    check_eq("rd_dbg_gnt",   32'(bus.dbg_gnt),    32'd0);
    check_eq("rd_stall",     32'(bus.cpu_stall),  32'd0);
    next_cycle(); idle();
    @(negedge clk);
    check_eq("rd_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd1);
    check_eq("rd_cpu_rdata",  32'(bus.cpu_rdata),  32'hBEEF);
    check_eq("rd_dbg_rvalid", 32'(bus.dbg_rvalid), 32'd0);
    next_cycle(); idle();
    @(negedge clk);
    check_eq("rd_rvalid_once", 32'(bus.cpu_rvalid), 32'd0);
    check_eq("rd_rdata_hold",  32'(bus.cpu_rdata),  32'hBEEF);
    check_eq("rd_dbg_rvalid2", 32'(bus.dbg_rvalid), 32'd0);

    // Contention: CPU wins 4, debug gets the 5th, repeating.
    for (int i = 0; i < 10; i++) begin
      next_cycle(); drive(1'b1, 1'b0, 8'h30, 16'h0000, 1'b1, 1'b0, 8'h31, 16'h0000, 1'b0);
      @(negedge clk);
      check_eq($sformatf("cont_cpu_gnt_%0d", i), 32'(bus.cpu_gnt),   (i % 5 != 4) ? 32'd1 : 32'd0);
      check_eq($sformatf("cont_dbg_gnt_%0d", i), 32'(bus.dbg_gnt),   (i % 5 == 4) ? 32'd1 : 32'd0);
      check_eq($sformatf("cont_stall_%0d", i),   32'(bus.cpu_stall), (i % 5 == 4) ? 32'd1 : 32'd0);
      check_eq($sformatf("cont_addr_%0d", i),    32'(bus.mem_addr),  (i % 5 == 4) ? 32'h31 : 32'h30);
    end
    next_cycle(); idle();
    @(negedge clk);
    check_eq("cont_dbg_rvalid", 32'(bus.dbg_rvalid), 32'd1);
    check_eq("cont_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);

    // Lock: debug writes 0x0001..0x0008 to 0x00..0x07.
    next_cycle(); drive(1'b0, 1'b0, 8'h40, 16'h0000, 1'b1, 1'b1, 8'h00, 16'h0001, 1'b1);
    @(negedge clk);
    check_eq("lk_first_gnt",  32'(bus.dbg_gnt), 32'd1);
    check_eq("lk_first_wr",   32'(bus.mem_wr),  32'd1);
    check_eq("lk_first_lock", 32'(bus.locked),  32'd0);
    for (int i = 1; i < 8; i++) begin
      next_cycle(); drive(1'b1, 1'b0, 8'h40, 16'h0000, 1'b1, 1'b1, 8'(i), 16'(i + 1), 1'b1);
      @(negedge clk);
      check_eq($sformatf("lk_locked_%0d", i), 32'(bus.locked),    32'd1);
      check_eq($sformatf("lk_dbg_gnt_%0d", i), 32'(bus.dbg_gnt),  32'd1);
      check_eq($sformatf("lk_cpu_gnt_%0d", i), 32'(bus.cpu_gnt),  32'd0);
      check_eq($sformatf("lk_stall_%0d", i),   32'(bus.cpu_stall), 32'd1);
      check_eq($sformatf("lk_wdata_%0d", i),   32'(bus.mem_wdata), 32'(i + 1));
    end
    next_cycle(); drive(1'b1, 1'b0, 8'h40, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0);
    @(negedge clk);
    check_eq("lk_drop_locked", 32'(bus.locked),    32'd1);
    check_eq("lk_drop_cpu",    32'(bus.cpu_gnt),   32'd0);
    check_eq("lk_drop_stall",  32'(bus.cpu_stall), 32'd1);
    next_cycle(); drive(1'b1, 1'b0, 8'h40, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0);
    @(negedge clk);
    check_eq("lk_arb_locked", 32'(bus.locked),   32'd0);
    check_eq("lk_arb_cpu",    32'(bus.cpu_gnt),  32'd1);
    check_eq("lk_arb_addr",   32'(bus.mem_addr), 32'h40);
    check_eq("lk_mem0",       32'(mem[0]),       32'h0001);
    check_eq("lk_mem7",       32'(mem[7]),       32'h0008);

    // Interleaved reads: CPU 0x20 then debug 0x21.
    next_cycle(); idle();
    next_cycle(); drive(1'b1, 1'b0, 8'h20, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0);
    @(negedge clk);
    check_eq("il_cpu_gnt", 32'(bus.cpu_gnt), 32'd1);
    next_cycle(); drive(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 8'h21, 16'h0000, 1'b0);
    @(negedge clk);
    check_eq("il_dbg_gnt",    32'(bus.dbg_gnt),    32'd1);
    check_eq("il_dbg_addr",   32'(bus.mem_addr),   32'h21);
    check_eq("il_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd1);
    check_eq("il_cpu_rdata",  32'(bus.cpu_rdata),  32'h1234);
    check_eq("il_dbg_rv0",    32'(bus.dbg_rvalid), 32'd0);
    next_cycle(); idle();
    @(negedge clk);
    check_eq("il_dbg_rvalid", 32'(bus.dbg_rvalid), 32'd1);
    check_eq("il_dbg_rdata",  32'(bus.dbg_rdata),  32'h5678);
    check_eq("il_cpu_rv0",    32'(bus.cpu_rvalid), 32'd0);
    check_eq("il_cpu_hold",   32'(bus.cpu_rdata),  32'h1234);

    // Reset mid-read with the starvation counter part-way up.
    for (int i = 0; i < 3; i++) begin
      next_cycle(); drive(1'b1, 1'b0, 8'h10, 16'h0000, 1'b1, 1'b0, 8'h11, 16'h0000, 1'b0);
      @(negedge clk);
      check_eq($sformatf("mr_cpu_gnt_%0d", i), 32'(bus.cpu_gnt), 32'd1);
    end
    next_cycle(); rst = 1'b1;
    @(negedge clk);
    check_all_zero("mr_rst");
    next_cycle(); rst = 1'b0; idle();
    @(negedge clk);
    check_all_zero("mr_after");
    for (int i = 0; i < 5; i++) begin
      next_cycle(); drive(1'b1, 1'b0, 8'h30, 16'h0000, 1'b1, 1'b0, 8'h31, 16'h0000, 1'b0);
      @(negedge clk);
      check_eq($sformatf("mr_cnt_cpu_%0d", i), 32'(bus.cpu_gnt), (i < 4) ? 32'd1 : 32'd0);
      check_eq($sformatf("mr_cnt_dbg_%0d", i), 32'(bus.dbg_gnt), (i < 4) ? 32'd0 : 32'd1);
    end

    next_cycle(); idle();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the processor's single 256x16 data/program memory port between two requesters: the CPU controller (fetch, LD, SW) and a debug/program-loader port.
- Sits between the controller/datapath and the memory.
- Provides a request/grant handshake, fixed CPU priority with anti-starvation for debug, and a debug bus-lock mode for bulk program loading.
- Routes one-cycle-latency read data back to the owner of each read.

Parameters:
- AW, 8, memory address width.
- DW, 16, memory data width.
- STARVE_LIMIT, 4, consecutive contested cycles the CPU may win before debug gets one forced grant (1..15).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU access request; held with its command until cpu_gnt.
- cpu_wr  in  1  1 = write, 0 = read.
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  DW  CPU write data.
- cpu_gnt  out  1  CPU command issued this cycle (combinational).
- cpu_rvalid  out  1  cpu_rdata valid (registered).
- cpu_rdata  out  DW  read data for the CPU.
- dbg_req, dbg_wr, dbg_addr, dbg_wdata  in  1/1/AW/DW  debug request, same rules as the CPU request.
- dbg_lock  in  1  request exclusive ownership for the debug port.
- dbg_gnt  out  1  debug command issued this cycle.
- dbg_rvalid  out  1  dbg_rdata valid.
- dbg_rdata  out  DW  read data for debug.
- mem_rd, mem_wr  out  1  memory strobes (combinational from the granted requester).
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  synchronous-read data, valid the cycle after mem_rd.
- cpu_stall  out  1  cpu_req high and cpu_gnt low this cycle.
- locked  out  1  FSM in LOCK state.

Behaviour:
- Reset values: every output is 0. The FSM enters ARB, starve_cnt = 0, and the pending-read tag is cleared.
- At most one grant per cycle. A grant issues the command in the same cycle: mem_addr, mem_wdata and mem_wr/mem_rd are taken from the winner. With no grant, mem_rd = mem_wr = 0 and addr/wdata hold 0.
- Read latency: a read granted in cycle N produces the owner's rvalid in cycle N+1, for exactly one cycle, with rdata = mem_rdata.
- The non-owner's rdata holds its last value, and its rvalid is 0.
- Write grants produce no rvalid.

FSM states:
- ARB:
  - Only one requester active: that requester is granted.
  - Both active: the CPU wins unless starve_cnt == STARVE_LIMIT, in which case debug wins.
  - starve_cnt increments on each contested CPU win and clears on any debug grant or any uncontested cycle.
  - dbg_lock and dbg_req high with a debug grant this cycle: go to LOCK next cycle.
- LOCK:
  - Only debug is granted. cpu_gnt = 0 and cpu_stall follows cpu_req.
  - starve_cnt is held at 0.
  - dbg_lock low: go to ARB next cycle. A dbg_req in that same cycle is still granted under LOCK.
- Simultaneous events:
  - A read grant in cycle N and a new grant in cycle N+1 are legal back-to-back. The tag register keeps each rvalid routed correctly.
  - Back-to-back reads from different owners alternate rvalid correctly.
- Reset mid-operation: an outstanding read tag is discarded, so no rvalid appears in the cycle after reset. A LOCK in progress is abandoned.
- Requester protocol violation (req dropped before gnt): that cycle's arbitration uses only the current req; no error flag.
- Debug-issued write to an address the CPU is fetching: no hazard logic. Ordering is grant order.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state encoding ARB = 0, LOCK = 1;
  - owner tag constants OWN_CPU = 0, OWN_DBG = 1;
  - default widths AW/DW.
- One natural sub-module, read_return_router: a 1-cycle tag pipeline plus rvalid/rdata demux. It is reusable if a third requester is added.
- The arbiter FSM and starvation counter stay in the top.

Test Plan:
- CPU read only: cpu_req = 1, cpu_wr = 0, cpu_addr = 0x10, memory[0x10] = 0xBEEF -> cpu_gnt in cycle 0; cpu_rvalid = 1 with cpu_rdata = 0xBEEF in cycle 1; dbg_rvalid = 0 throughout.
- Contention with STARVE_LIMIT = 4: cpu_req and dbg_req held high continuously -> cpu_gnt for 4 cycles, dbg_gnt in cycle 5, then the pattern repeats; cpu_stall = 1 only in the debug cycles.
- Lock: dbg_lock = 1, dbg writes 0x0001..0x0008 to 0x00..0x07 while cpu_req = 1 -> locked = 1 from cycle 1; 8 dbg_gnt; cpu_gnt = 0. Drop dbg_lock -> ARB next cycle, then cpu_gnt.
- Interleaved reads: CPU read of 0x20 in cycle N, debug read of 0x21 in cycle N+1 (no contention) -> cpu_rvalid in N+1, dbg_rvalid in N+2, each with the correct data.
- Reset mid-read: read granted in cycle N, rst = 1 in cycle N+1 -> all outputs 0, no rvalid in N+1 or N+2, starve_cnt = 0, FSM in ARB.
- Idle: no requests -> mem_rd = mem_wr = 0, mem_addr = 0, no grants.
